// File: rtl/sram_arbiter_pkg.sv
// Shared types for the SRAM arbiter: FSM state, access owner, and default wait states.
package sram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

  localparam int WAIT_STATES_DEFAULT = 1;

endpackage

// File: rtl/sram_arbiter.sv
// Two-port (CPU/DMA) arbiter onto one asynchronous SRAM, one access in flight.
// Handshake: each requester holds its request level until a one-cycle ready/ack pulse.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int WAIT_STATES = WAIT_STATES_DEFAULT,
  parameter int AW          = 19
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [3:0]    cpu_be,
  input  logic [31:0]   cpu_wdata,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_ready,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [3:0]    dma_be,
  input  logic [31:0]   dma_wdata,
  output logic [31:0]   dma_rdata,
  output logic          dma_ack,
  output logic          ram_cs_b,
  output logic          ram_oe_b,
  output logic          ram_wr_b,
  output logic [3:0]    ram_be_b,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_dout,
  output logic          ram_drive,
  input  logic [31:0]   ram_din,
  output state_e        dbg_state
);

  state_e        state_q, state_d;
  owner_e        owner_q, last_owner_q;
  logic          write_q;
  logic [AW-1:0] addr_q;
  logic [3:0]    be_q;
  logic [31:0]   wdata_q;
  logic [2:0]    cnt_q;

  logic cpu_pend, dma_pend, grant, grant_dma, last_access;

  assign cpu_pend    = cpu_rd | cpu_wr;
  assign dma_pend    = dma_req;
  // DMA wins only when CPU is idle or CPU took the previous grant.
  assign grant_dma   = dma_pend && (!cpu_pend || last_owner_q == OWN_CPU);
  assign grant       = (state_q == IDLE) && (cpu_pend || dma_pend);
  assign last_access = (state_q == ACCESS) && (cnt_q == 3'd0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = ACCESS;
      ACCESS:  if (cnt_q == 3'd0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_CPU;
      last_owner_q <= OWN_DMA;
      write_q      <= 1'b0;
      addr_q       <= '0;
      be_q         <= 4'h0;
      wdata_q      <= 32'h0;
      cnt_q        <= 3'd0;
      cpu_rdata    <= 32'h0;
      dma_rdata    <= 32'h0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        owner_q      <= grant_dma ? OWN_DMA : OWN_CPU;
        last_owner_q <= grant_dma ? OWN_DMA : OWN_CPU;
        write_q      <= grant_dma ? dma_we : cpu_wr;
        addr_q       <= grant_dma ? dma_addr : cpu_addr;
        be_q         <= grant_dma ? dma_be : cpu_be;
        wdata_q      <= grant_dma ? dma_wdata : cpu_wdata;
        cnt_q        <= 3'(WAIT_STATES);
      end else if (state_q == ACCESS && cnt_q != 3'd0) begin
        cnt_q <= cnt_q - 3'd1;
      end
      if (last_access && !write_q) begin
        if (owner_q == OWN_CPU) cpu_rdata <= ram_din;
        else                    dma_rdata <= ram_din;
      end
    end
  end

  // Write data and pad drive stay up through DONE to give the SRAM hold time.
  always_comb begin
    ram_cs_b  = 1'b1;
    ram_oe_b  = 1'b1;
    ram_wr_b  = 1'b1;
    ram_be_b  = 4'hF;
    ram_drive = 1'b0;
    case (state_q)
      ACCESS: begin
        ram_cs_b  = 1'b0;
        ram_be_b  = ~be_q;
        ram_oe_b  = write_q;
        ram_wr_b  = ~write_q;
        ram_drive = write_q;
      end
      DONE:    ram_drive = write_q;
      default: ;
    endcase
  end

  assign ram_addr  = addr_q;
  assign ram_dout  = wdata_q;
  assign cpu_ready = (state_q == DONE) && (owner_q == OWN_CPU);
  assign dma_ack   = (state_q == DONE) && (owner_q == OWN_DMA);
  assign dbg_state = state_q;

endmodule
